formula_2_inv_pipe: RTL and testbench

Pipelined inverse of the nested square-root formula `res = isqrt(a + isqrt(b + isqrt(c)))`. For a target result `s` and operands `a` and `b`, the block computes the smallest `c` that produces `s`, or flags that no such `c` exists. It is the decoder side of the `formula_2` datapath and sits in the same arithmetic/pipelining group. Benches use it to generate directed `c` stimulus and to close the loop on the forward pipe.

---
 rtl/formula_2_inv_pipe.sv | 109 ++++++++++
 tb/tb_formula_2_inv_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/formula_2_inv_pipe.sv
// Five-stage inverse of res = isqrt(a + isqrt(b + isqrt(c))): returns the smallest c
// that yields target s, or flags that none exists. One result per cycle, fixed latency 5.
module formula_2_inv_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arg_vld,
    input  logic [15:0] s,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        res_vld,
    output logic [31:0] res,
    output logic        res_err,
    output logic [15:0] err_cnt
);

    function automatic logic [31:0] mul16(input logic [15:0] x, input logic [15:0] y);
        return {16'd0, x} * {16'd0, y};
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    logic        vld_p1, vld_p2, vld_p3, vld_p4;
    logic [31:0] sq1_p1, a_p1, b_p1;
    logic [15:0] v_p2;
    logic [31:0] b_p2;
    logic        err_p2;
    logic [31:0] sq2_p3, b_p3;
    logic        err_p3;
    logic [15:0] w_p4;
    logic        err_p4;

    logic [31:0] diff_p1;
    logic [31:0] diff_p3;

    assign diff_p1 = sq1_p1 - a_p1;
    assign diff_p3 = sq2_p3 - b_p3;

    // Valid chain: the only state cleared by reset inside the pipe, so in-flight work is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            vld_p3  <= 1'b0;
            vld_p4  <= 1'b0;
            res_vld <= 1'b0;
        end else begin
            vld_p1  <= arg_vld;
            vld_p2  <= vld_p1;
            vld_p3  <= vld_p2;
            vld_p4  <= vld_p3;
            res_vld <= vld_p4;
        end
    end

    // Stage 1: square the target
    always_ff @(posedge clk) begin
        if (arg_vld) begin
            sq1_p1 <= mul16(s, s);
            a_p1   <= a;
            b_p1   <= b;
        end
    end

    // Stage 2: peel off a; v must be a legal 16-bit isqrt output
    always_ff @(posedge clk) begin
        if (vld_p1) begin
            v_p2   <= diff_p1[15:0];
            err_p2 <= (sq1_p1 < a_p1) | (diff_p1[31:16] != 16'd0);
            b_p2   <= b_p1;
        end
    end

    // Stage 3: square v
    always_ff @(posedge clk) begin
        if (vld_p2) begin
            sq2_p3 <= mul16(v_p2, v_p2);
            err_p3 <= err_p2;
            b_p3   <= b_p2;
        end
    end

    // Stage 4: peel off b; w must also fit in 16 bits
    always_ff @(posedge clk) begin
        if (vld_p3) begin
            w_p4   <= diff_p3[15:0];
            err_p4 <= err_p3 | (sq2_p3 < b_p3) | (diff_p3[31:16] != 16'd0);
        end
    end

    // Stage 5: c = w*w, forced to zero on error; outputs hold between results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res     <= 32'd0;
            res_err <= 1'b0;
            err_cnt <= 16'd0;
        end else begin
            if (vld_p4) begin
                res     <= err_p4 ? 32'd0 : mul16(w_p4, w_p4);
                res_err <= err_p4;
            end
            if (res_vld && res_err) begin
                err_cnt <= sat_inc16(err_cnt);
            end
        end
    end

endmodule

// File: tb/tb_formula_2_inv_pipe.sv
// Scoreboard bench for formula_2_inv_pipe: reference model, forward-formula round trip,
// latency, reset-drop and error-counter saturation.
module tb_formula_2_inv_pipe;

    logic        clk;
    logic        rst_n;
    logic        arg_vld;
    logic [15:0] s;
    logic [31:0] a;
    logic [31:0] b;
    logic        res_vld;
    logic [31:0] res;
    logic        res_err;
    logic [15:0] err_cnt;

    formula_2_inv_pipe dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .arg_vld (arg_vld),
        .s       (s),
        .a       (a),
        .b       (b),
        .res_vld (res_vld),
        .res     (res),
        .res_err (res_err),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        err;
        logic [15:0] s;
        logic [31:0] a;
        logic [31:0] b;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int          n_tests;
    int          n_fail;
    logic [15:0] exp_cnt;
    logic [31:0] last_res;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] isqrt(input logic [63:0] x);
        logic [63:0] op, r, one;
        op  = x;
        r   = 64'd0;
        one = 64'h4000_0000_0000_0000;
        while (one > op) one = one >> 2;
        while (one != 64'd0) begin
            if (op >= r + one) begin
                op = op - (r + one);
                r  = (r >> 1) + one;
            end else begin
                r = r >> 1;
            end
            one = one >> 2;
        end
        return r;
    endfunction

    function automatic logic [63:0] fwd(input logic [63:0] c, input logic [31:0] fa, input logic [31:0] fb);
        return isqrt({32'd0, fa} + isqrt({32'd0, fb} + isqrt(c)));
    endfunction

    task automatic ref_model(input logic [15:0] ms, input logic [31:0] ma, input logic [31:0] mb,
                             output logic [31:0] mres, output logic merr);
        logic [63:0] ss, v, vv, w;
        mres = 32'd0;
        merr = 1'b1;
        ss = {48'd0, ms} * {48'd0, ms};
        if (ss < {32'd0, ma}) return;
        v = ss - {32'd0, ma};
        if (v > 64'hFFFF) return;
        vv = v * v;
        if (vv < {32'd0, mb}) return;
        w = vv - {32'd0, mb};
        if (w > 64'hFFFF) return;
        mres = 32'(w * w);
        merr = 1'b0;
    endtask

    task automatic drive(input logic [15:0] ds, input logic [31:0] da, input logic [31:0] db);
        exp_t e;
        @(posedge clk);
        #1;
        arg_vld = 1'b1;
        s = ds;
        a = da;
        b = db;
        ref_model(ds, da, db, e.res, e.err);
        e.s = ds;
        e.a = da;
        e.b = db;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            arg_vld = 1'b0;
            s = 16'($urandom);
            a = $urandom;
            b = $urandom;
        end
    endtask

    task automatic rand_drive();
        int unsigned rs, ra, rb, vv;
        if ($urandom_range(0, 3) == 0) begin
            drive(16'($urandom), $urandom, $urandom);
        end else begin
            rs = $urandom_range(0, 24);
            ra = $urandom_range(0, rs * rs + 2);
            vv = (ra <= rs * rs) ? (rs * rs - ra) * (rs * rs - ra) : 0;
            rb = $urandom_range(0, vv + 2);
            drive(16'(rs), ra, rb);
        end
    endtask

    // Output monitor: every res_vld must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (res_vld) begin
            if (sb.size() == 0) begin
                chk("unexpected_vld", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("res", {32'd0, res}, {32'd0, e.res});
                chk("res_err", {63'd0, res_err}, {63'd0, e.err});
                chk("latency", 64'(cyc - e.cyc), 64'd5);
                if (!e.err) begin
                    chk("fwd", fwd({32'd0, res}, e.a, e.b), {48'd0, e.s});
                    if (res != 32'd0)
                        chk("fwd_minus1", {63'd0, fwd({32'd0, res} - 64'd1, e.a, e.b) == {48'd0, e.s}}, 64'd0);
                end
                if (e.err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                last_res = e.res;
            end
        end
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        exp_cnt  = 16'd0;
        last_res = 32'd0;
        cyc      = 0;
        rst_n    = 1'b0;
        arg_vld  = 1'b1;
        s = 16'd3;
        a = 32'd5;
        b = 32'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_res_vld", {63'd0, res_vld}, 64'd0);
        chk("rst_res", {32'd0, res}, 64'd0);
        chk("rst_res_err", {63'd0, res_err}, 64'd0);
        chk("rst_err_cnt", {48'd0, err_cnt}, 64'd0);
        @(posedge clk);
        #1;
        arg_vld = 1'b0;
        rst_n = 1'b1;
        idle(6);
        chk("no_vld_from_reset", {32'd0, 32'(sb.size())}, 64'd0);

        // Directed: nominal, zero, largest legal, then one per error condition.
        drive(16'd3, 32'd5, 32'd2);
        drive(16'd0, 32'd0, 32'd0);
        drive(16'd15, 32'd0, 32'd0);
        idle(2);
        drive(16'd2, 32'd5, 32'd0);
        drive(16'd300, 32'd0, 32'd0);
        drive(16'd2, 32'd0, 32'd20);
        drive(16'd16, 32'd0, 32'd0);
        idle(8);
        chk("directed_drain", {32'd0, 32'(sb.size())}, 64'd0);
        chk("err_cnt_4", {48'd0, err_cnt}, 64'd4);

        // Random, gapped.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            rand_drive();
        end
        idle(8);
        chk("random_drain", {32'd0, 32'(sb.size())}, 64'd0);
        chk("err_cnt_random", {48'd0, err_cnt}, {48'd0, exp_cnt});
        chk("res_hold", {32'd0, res}, {32'd0, last_res});

        // Reset mid-stream drops three in-flight operations.
        drive(16'd2, 32'd5, 32'd0);
        drive(16'd2, 32'd5, 32'd0);
        drive(16'd3, 32'd5, 32'd2);
        @(posedge clk);
        #1;
        arg_vld = 1'b1;
        rst_n = 1'b0;
        sb.delete();
        exp_cnt = 16'd0;
        @(posedge clk);
        #1;
        arg_vld = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("err_cnt_after_rst", {48'd0, err_cnt}, 64'd0);
        chk("res_vld_after_rst", {63'd0, res_vld}, 64'd0);
        idle(8);
        drive(16'd3, 32'd5, 32'd2);
        idle(8);
        chk("post_rst_drain", {32'd0, 32'(sb.size())}, 64'd0);
        chk("post_rst_res", {32'd0, res}, 64'd196);

        // Saturation: 65540 back-to-back error results.
        for (int i = 0; i < 65540; i++) drive(16'd2, 32'd5, 32'd0);
        idle(8);
        chk("sat_drain", {32'd0, 32'(sb.size())}, 64'd0);
        chk("err_cnt_sat", {48'd0, err_cnt}, 64'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
